// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: checks HS/VS timing against expected geometry and tracks lock
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    output logic        o_locked,
    output logic        o_frame_stb,
    output logic        o_err,
    output logic [7:0]  o_err_cnt,
    output logic [11:0] o_line_len,
    output logic [11:0] o_frame_lines
);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {ACQUIRE, CHECK, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] good_q, good_d, good_inc;
    logic [11:0]   hcnt_q, hcnt_d, hsw_q, hsw_d, vcnt_q, vcnt_d, vsw_q, vsw_d;
    logic [11:0]   line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic          hs_prev_q, vs_prev_q, h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic          frame_bad_q, frame_bad_d, frame_stb_q, err_q;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          hs_act, vs_act, hs_lead, hs_trail, vs_lead, vs_trail;
    logic [11:0]   hinc, flines;
    logic          line_err, hsw_err, vsw_err, frame_err, timeout, err_any, frame_ok;

    assign hs_act    = (i_hs == SYNC_POL);
    assign vs_act    = (i_vs == SYNC_POL);
    assign hs_lead   = i_pix_stb & hs_act & ~hs_prev_q;
    assign hs_trail  = i_pix_stb & ~hs_act & hs_prev_q;
    assign vs_lead   = i_pix_stb & vs_act & ~vs_prev_q;
    assign vs_trail  = i_pix_stb & ~vs_act & vs_prev_q;
    assign hinc      = (&hcnt_q) ? hcnt_q : hcnt_q + 12'd1;
    assign flines    = (hs_lead && !(&vcnt_q)) ? vcnt_q + 12'd1 : vcnt_q;
    assign line_err  = hs_lead & h_seen_q & (hinc != 12'(H_TOTAL));
    assign hsw_err   = hs_trail & h_seen_q & (hsw_q != 12'(H_SYNC));
    assign vsw_err   = vs_trail & v_seen_q & (vsw_q != 12'(V_SYNC));
    assign frame_err = vs_lead & v_seen_q & (flines != 12'(V_TOTAL));
    // fires once, on the strobe that carries hcnt into saturation
    assign timeout   = i_pix_stb & ~hs_lead & (hcnt_q == 12'hFFE);
    assign err_any   = line_err | hsw_err | vsw_err | frame_err | timeout;
    assign frame_ok  = ~(frame_bad_q | err_any);
    assign good_inc  = good_q + 1'b1;

    assign o_locked      = (state_q == LOCKED);
    assign o_frame_stb   = frame_stb_q;
    assign o_err         = err_q;
    assign o_err_cnt     = err_cnt_q;
    assign o_line_len    = line_len_q;
    assign o_frame_lines = frame_lines_q;

    // measurement datapath: counters, widths, seen flags and captured values
    always_comb begin
        hcnt_d        = hcnt_q;
        hsw_d         = hsw_q;
        vcnt_d        = vcnt_q;
        vsw_d         = vsw_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        h_seen_d      = h_seen_q;
        v_seen_d      = v_seen_q;
        frame_bad_d   = frame_bad_q;
        err_cnt_d     = (err_any && !(&err_cnt_q)) ? err_cnt_q + 8'd1 : err_cnt_q;
        if (i_pix_stb) begin
            hcnt_d      = hinc;
            hsw_d       = (hs_act && !(&hsw_q)) ? hsw_q + 12'd1 : hsw_q;
            frame_bad_d = vs_lead ? 1'b0 : (frame_bad_q | err_any);
            if (hs_lead) begin
                line_len_d = hinc;
                hcnt_d     = '0;
                hsw_d      = 12'd1;
                h_seen_d   = 1'b1;
                vcnt_d     = (&vcnt_q) ? vcnt_q : vcnt_q + 12'd1;
                vsw_d      = (vs_act && !(&vsw_q)) ? vsw_q + 12'd1 : vsw_q;
            end
            if (vs_lead) begin
                frame_lines_d = flines;
                vcnt_d        = {11'd0, hs_lead};
                vsw_d         = {11'd0, hs_lead};
                v_seen_d      = 1'b1;
            end
            if (timeout) begin
                h_seen_d = 1'b0;
                v_seen_d = 1'b0;
            end
        end
    end

    // lock FSM next state; timeout overrides everything
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            ACQUIRE: if (vs_lead) begin
                state_d = CHECK;
                good_d  = '0;
            end
            CHECK: if (vs_lead) begin
                good_d  = frame_ok ? good_inc : '0;
                state_d = (frame_ok && good_inc == LOCK_N) ? LOCKED : CHECK;
            end
            LOCKED: if (err_any) begin
                state_d = CHECK;
                good_d  = '0;
            end
            default: state_d = ACQUIRE;
        endcase
        if (timeout) begin
            state_d = ACQUIRE;
            good_d  = '0;
        end
    end

    // state registers; previous sync samples advance only on strobes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ACQUIRE;
            good_q        <= '0;
            hcnt_q        <= '0;
            hsw_q         <= '0;
            vcnt_q        <= '0;
            vsw_q         <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            frame_bad_q   <= 1'b0;
            frame_stb_q   <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            hcnt_q        <= hcnt_d;
            hsw_q         <= hsw_d;
            vcnt_q        <= vcnt_d;
            vsw_q         <= vsw_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            hs_prev_q     <= i_pix_stb ? hs_act : hs_prev_q;
            vs_prev_q     <= i_pix_stb ? vs_act : vs_prev_q;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            frame_bad_q   <= frame_bad_d;
            frame_stb_q   <= vs_lead;
            err_q         <= err_any;
            err_cnt_q     <= err_cnt_d;
        end
    end
endmodule
